// File: rtl/pipe_dmem.sv
// ---------------------------------------------------------------------------
// pipe_dmem
// Pipelined data memory for the three-stage RISC-V core: two independent
// read ports, one byte-strobed write port, READ_LAT-deep {valid, data}
// pipeline per read port, write-first forwarding on same-edge collisions and
// a sticky error flag for out-of-range accesses.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset (array is not cleared)
//   rd1_req / rd2_req   read request, accepted every cycle it is high
//   rd1_addr / rd2_addr word address of the read
//   rd1_valid/rd2_valid one-cycle pulse per accepted read, READ_LAT later
//   rd1_data / rd2_data read data, holds its last value while valid is low
//   wr_req              write request
//   wr_addr             word address of the write
//   wr_data             write data
//   wr_be               byte lane enables, bit i covers bits [8i+7:8i]
//   err                 sticky out-of-range flag, cleared only by rst
// ---------------------------------------------------------------------------
module pipe_dmem #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd1_req,
    input  logic [ADDR_W-1:0]     rd1_addr,
    output logic                  rd1_valid,
    output logic [DATA_W-1:0]     rd1_data,
    input  logic                  rd2_req,
    input  logic [ADDR_W-1:0]     rd2_addr,
    output logic                  rd2_valid,
    output logic [DATA_W-1:0]     rd2_data,
    input  logic                  wr_req,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    output logic                  err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH widened by one bit so DEPTH == 2**ADDR_W is still representable
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Replace the enabled byte lanes of old_w with new_w.
    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              rd_req_s      [2];
    logic [ADDR_W-1:0] rd_addr_s     [2];
    logic              rd_in_range_s [2];
    logic [NB-1:0]     fwd_be_s      [2];
    logic [DATA_W-1:0] rd_word_s     [2];
    logic              wr_in_range_s;
    logic              wr_en_s;
    logic              err_d;

    logic              valid_q [2][READ_LAT];
    logic [DATA_W-1:0] data_q  [2][READ_LAT];
    logic              err_q;

    // Stage-0 read word per port, including same-edge write forwarding, and next error state.
    always_comb begin
        rd_req_s[0]   = rd1_req;
        rd_req_s[1]   = rd2_req;
        rd_addr_s[0]  = rd1_addr;
        rd_addr_s[1]  = rd2_addr;
        wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
        wr_en_s       = wr_req & wr_in_range_s;
        for (int p = 0; p < 2; p++) begin
            rd_in_range_s[p] = ({1'b0, rd_addr_s[p]} < DEPTH_L);
            // Only lanes actually written at this edge are forwarded; the rest come from the array.
            if (wr_en_s && (wr_addr == rd_addr_s[p])) begin
                fwd_be_s[p] = wr_be;
            end else begin
                fwd_be_s[p] = {NB{1'b0}};
            end
            if (rd_in_range_s[p]) begin
                rd_word_s[p] = merge_word(mem_q[rd_addr_s[p][IDX_W-1:0]], wr_data, fwd_be_s[p]);
            end else begin
                rd_word_s[p] = {DATA_W{1'b0}};
            end
        end
        err_d = err_q
              | (wr_req   & ~wr_in_range_s)
              | (rd_req_s[0] & ~rd_in_range_s[0])
              | (rd_req_s[1] & ~rd_in_range_s[1]);
    end

    // Array write: enabled lanes only; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_addr[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read pipelines and sticky error; each stage's data only moves with a valid token so the output holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < READ_LAT; s++) begin
                    valid_q[p][s] <= 1'b0;
                    data_q[p][s]  <= {DATA_W{1'b0}};
                end
            end
            err_q <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                valid_q[p][0] <= rd_req_s[p];
                if (rd_req_s[p]) begin
                    data_q[p][0] <= rd_word_s[p];
                end
                for (int s = 1; s < READ_LAT; s++) begin
                    valid_q[p][s] <= valid_q[p][s-1];
                    if (valid_q[p][s-1]) begin
                        data_q[p][s] <= data_q[p][s-1];
                    end
                end
            end
            err_q <= err_d;
        end
    end

    assign rd1_valid = valid_q[0][READ_LAT-1];
    assign rd1_data  = data_q[0][READ_LAT-1];
    assign rd2_valid = valid_q[1][READ_LAT-1];
    assign rd2_data  = data_q[1][READ_LAT-1];
    assign err       = err_q;

endmodule
